// File: rtl/modulo_conversor_bcd_rolhas_pkg.sv
// Shared types and constants for the binary-to-BCD converter on the cork-count path.
package pacote_conversor_bcd;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    DESLOCA = 2'd1,
    CONCLUI = 2'd2
  } estado_t;

  localparam int LARG_DIGITO     = 4;
  localparam int LIMIAR_CORRECAO = 5;
  localparam int OFFSET_CORRECAO = 3;

  // 10^n at elaboration; 64 bits so DIGITS=10 (10^10) still fits.
  function automatic longint unsigned pot10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/modulo_conversor_bcd_rolhas_if.sv
// Request/result bundle between the cork counter and the BCD converter.
interface modulo_conversor_bcd_rolhas_if #(
  parameter int WIDTH  = 7,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      valor_bin;
  logic                  busy;
  logic                  valido;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     mascara_zero;
  logic                  overflow;

  modport master (
    output start, valor_bin,
    input  busy, valido, bcd, mascara_zero, overflow
  );

  modport slave (
    input  start, valor_bin,
    output busy, valido, bcd, mascara_zero, overflow
  );
endinterface

// File: rtl/modulo_conversor_bcd_rolhas_corretor.sv
// Per-digit double-dabble correction: digits >= 5 get +3 before the shift.
module modulo_corretor_digito
  import pacote_conversor_bcd::*;
(
  input  logic [LARG_DIGITO-1:0] digito_in,
  output logic [LARG_DIGITO-1:0] digito_out
);
  assign digito_out = (digito_in >= LARG_DIGITO'(LIMIAR_CORRECAO))
                    ? digito_in + LARG_DIGITO'(OFFSET_CORRECAO)
                    : digito_in;
endmodule

// File: rtl/modulo_conversor_bcd_rolhas.sv
// Iterative binary-to-BCD converter (one input bit per clock) with leading-zero
// mask and saturating overflow for the 7-segment display drivers.
module modulo_conversor_bcd_rolhas
  import pacote_conversor_bcd::*;
#(
  parameter int WIDTH  = 7,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          reset_n,
  modulo_conversor_bcd_rolhas_if.slave  bus
);
  localparam int BCD_W = LARG_DIGITO * DIGITS;
  localparam int SR_W  = BCD_W + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam longint unsigned LIMITE = pot10(DIGITS) - 64'd1;
  // When every WIDTH-bit value fits in DIGITS digits the comparator is dropped.
  localparam bit SEM_OVF = (((64'd1 << WIDTH) - 64'd1) <= LIMITE);
  localparam logic [DIGITS-1:0] MASC_RST = {DIGITS{1'b1}} << 1;

  estado_t            estado;
  logic [SR_W-1:0]    sr;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_int;
  logic               busy_q, valido_q, ovf_q;
  logic [BCD_W-1:0]   bcd_q, bcd_corr;
  logic [DIGITS-1:0]  mascara_q, mascara_calc;
  logic               zeros_acima;

  // Correct every BCD digit in parallel ahead of the shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    modulo_corretor_digito u_corr (
      .digito_in  (sr[WIDTH + LARG_DIGITO*g +: LARG_DIGITO]),
      .digito_out (bcd_corr[LARG_DIGITO*g +: LARG_DIGITO])
    );
  end

  // Leading-zero mask from the final BCD field; units digit is never blanked.
  always_comb begin
    mascara_calc = '0;
    zeros_acima  = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zeros_acima     = zeros_acima & (sr[WIDTH + LARG_DIGITO*k +: LARG_DIGITO] == '0);
      mascara_calc[k] = zeros_acima;
    end
  end

  // Control FSM, shift datapath and registered results.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado    <= OCIOSO;
      sr        <= '0;
      cnt       <= '0;
      ovf_int   <= 1'b0;
      busy_q    <= 1'b0;
      valido_q  <= 1'b0;
      bcd_q     <= '0;
      mascara_q <= MASC_RST;
      ovf_q     <= 1'b0;
    end else begin
      valido_q <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (bus.start) begin
            sr      <= {BCD_W'(0), bus.valor_bin};
            cnt     <= CNT_W'(WIDTH);
            ovf_int <= SEM_OVF ? 1'b0 : (64'(bus.valor_bin) > LIMITE);
            busy_q  <= 1'b1;
            estado  <= DESLOCA;
          end
        end
        DESLOCA: begin
          sr  <= {bcd_corr[BCD_W-2:0], sr[WIDTH-1:0], 1'b0};
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) estado <= CONCLUI;
        end
        CONCLUI: begin
          valido_q <= 1'b1;
          busy_q   <= 1'b0;
          ovf_q    <= ovf_int;
          if (ovf_int) begin
            bcd_q     <= {DIGITS{4'h9}};
            mascara_q <= '0;
          end else begin
            bcd_q     <= sr[SR_W-1 -: BCD_W];
            mascara_q <= mascara_calc;
          end
          estado <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.valido       = valido_q;
  assign bus.bcd          = bcd_q;
  assign bus.mascara_zero = mascara_q;
  assign bus.overflow     = ovf_q;

endmodule
